// File: rtl/fir_run_controller_if.sv
// Handshake and status bundle between the run controller and the FIR datapath.
//   dp_ack        : datapath has consumed the current sample request
//   dp_clr        : one-cycle clear of the datapath registers
//   smp_req       : sample request, held until dp_ack
//   running       : controller is in a clear/run/wait phase
//   done          : sample limit reached for this run
//   sample_count  : samples acknowledged in the current run
interface fir_run_controller_if #(
  parameter int unsigned CNT_W = 35
);
  logic             dp_ack;
  logic             dp_clr;
  logic             smp_req;
  logic             running;
  logic             done;
  logic [CNT_W-1:0] sample_count;

  modport master (
    input  dp_ack,
    output dp_clr, smp_req, running, done, sample_count
  );

  modport slave (
    output dp_ack,
    input  dp_clr, smp_req, running, done, sample_count
  );
endinterface

// File: rtl/fir_run_controller.sv
// Run/stop sequencer for the FIR / moving-average datapath.
// Debounces the active-low toggle key, clears the datapath on start, paces
// sample requests every SAMPLE_DIV clocks and counts acknowledged samples.
// Ports:
//   CLOCK_50   : system clock, posedge
//   reset      : asynchronous, active-high
//   toggleBtn  : raw active-low key, asynchronous to CLOCK_50
//   bus        : datapath handshake and status (master side)
module fir_run_controller #(
  parameter int unsigned DEB_CYCLES  = 500000,
  parameter int unsigned SAMPLE_DIV  = 50,
  parameter int unsigned MAX_SAMPLES = 0,
  parameter int unsigned CNT_W       = 35
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    toggleBtn,
  fir_run_controller_if.master    bus
);

  localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);
  localparam int unsigned DIV_W = $clog2(SAMPLE_DIV);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, WAIT, DONE} state_t;

  logic             key_meta;
  logic             key_sync;
  logic             key_level;
  logic [DEB_W-1:0] deb_cnt;
  logic             press;

  state_t           state, state_n;
  logic [DIV_W-1:0] div, div_n;
  logic [CNT_W-1:0] count, count_n;
  logic             stop_pending, stop_pending_n;
  logic             dp_clr_q, smp_req_q, running_q, done_q;

  // Key synchroniser and debouncer; press fires only on a debounced 1->0.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      key_meta  <= 1'b1;
      key_sync  <= 1'b1;
      key_level <= 1'b1;
      deb_cnt   <= '0;
      press     <= 1'b0;
    end else begin
      key_meta <= toggleBtn;
      key_sync <= key_meta;
      press    <= 1'b0;
      if (key_sync == key_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
        deb_cnt   <= '0;
        key_level <= key_sync;
        press     <= key_level;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end
  end

  // State and output registers; outputs are decoded from the next state.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      div          <= '0;
      count        <= '0;
      stop_pending <= 1'b0;
      dp_clr_q     <= 1'b0;
      smp_req_q    <= 1'b0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state        <= state_n;
      div          <= div_n;
      count        <= count_n;
      stop_pending <= stop_pending_n;
      dp_clr_q     <= (state_n == CLEAR);
      smp_req_q    <= (state_n == WAIT);
      running_q    <= (state_n == CLEAR) || (state_n == RUN) || (state_n == WAIT);
      done_q       <= (state_n == DONE);
    end
  end

  // Next-state logic; a finished run takes precedence over a pending stop.
  always_comb begin
    state_n        = state;
    div_n          = div;
    count_n        = count;
    stop_pending_n = stop_pending;
    case (state)
      IDLE: begin
        if (press) state_n = CLEAR;
      end
      CLEAR: begin
        count_n        = '0;
        div_n          = '0;
        stop_pending_n = 1'b0;
        state_n        = RUN;
      end
      RUN: begin
        if (press) begin
          state_n = IDLE;
        end else if (div == DIV_W'(SAMPLE_DIV - 1)) begin
          div_n   = '0;
          state_n = WAIT;
        end else begin
          div_n = div + DIV_W'(1);
        end
      end
      WAIT: begin
        if (press) stop_pending_n = 1'b1;
        if (bus.dp_ack) begin
          count_n = count + CNT_W'(1);
          if ((MAX_SAMPLES != 0) && (count_n == CNT_W'(MAX_SAMPLES))) begin
            state_n = DONE;
          end else if (stop_pending || press) begin
            stop_pending_n = 1'b0;
            state_n        = IDLE;
          end else begin
            state_n = RUN;
          end
        end
      end
      DONE: begin
        if (press) state_n = CLEAR;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.dp_clr       = dp_clr_q;
  assign bus.smp_req      = smp_req_q;
  assign bus.running      = running_q;
  assign bus.done         = done_q;
  assign bus.sample_count = count;

endmodule
